// File: rtl/alu_share_arbiter_pkg.sv
// Shared constants for the ALU sharing arbiter: ALU operation codes and arbiter FSM encodings.
package alu_share_arbiter_pkg;

  localparam logic [6:0] ALU_ADD  = 7'd0;
  localparam logic [6:0] ALU_SUB  = 7'd1;
  localparam logic [6:0] ALU_SLL  = 7'd2;
  localparam logic [6:0] ALU_REMU = 7'd3;
  localparam logic [6:0] ALU_AND  = 7'd4;
  localparam logic [6:0] ALU_OR   = 7'd5;
  localparam logic [6:0] ALU_XOR  = 7'd6;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_ISSUE = 2'd1;
  localparam logic [1:0] ARB_RESP  = 2'd2;

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin grant: with both requesters valid, the port that did not win last time wins.
module alu_share_arbiter_rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  assign grant_valid = |valid;

  always_comb begin
    grant_idx = valid[1];
    if (&valid) grant_idx = ~last_grant;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the execute stage (port 0) and address-gen/branch (port 1).
// Optional saturating performance counters are enabled with `define ALU_SHARE_PERF_CNT_EN.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 7
`ifdef ALU_SHARE_PERF_CNT_EN
  ,
  parameter int CNT_W  = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_ip1,
  input  logic [DATA_W-1:0] req0_ip2,
  input  logic [OP_W-1:0]   req0_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_zero,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_ip1,
  input  logic [DATA_W-1:0] req1_ip2,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_zero,
  output logic [DATA_W-1:0] alu_ip1,
  output logic [DATA_W-1:0] alu_ip2,
  output logic [OP_W-1:0]   alu_operation,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero_flag,
`ifdef ALU_SHARE_PERF_CNT_EN
  output logic [CNT_W-1:0]  perf_grant0,
  output logic [CNT_W-1:0]  perf_grant1,
  output logic [CNT_W-1:0]  perf_stall,
`endif
  output logic [1:0]        state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // Requesters hold valid and payload until ready; a response is held until rsp_ready.
  logic [1:0]        state;
  logic              last_grant;
  logic              owner;
  logic [DATA_W-1:0] ip1_q;
  logic [DATA_W-1:0] ip2_q;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] res_q;
  logic              zero_q;
  logic              grant_valid;
  logic              grant_idx;
  logic              in_idle;
  logic              rsp_take;

  alu_share_arbiter_rr_arb2 u_rr_arb2 (
    .valid       ({req1_valid, req0_valid}),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign in_idle    = (state == ARB_IDLE);
  assign req0_ready = in_idle && grant_valid && !grant_idx;
  assign req1_ready = in_idle && grant_valid && grant_idx;

  assign rsp0_valid  = (state == ARB_RESP) && !owner;
  assign rsp1_valid  = (state == ARB_RESP) && owner;
  assign rsp0_result = res_q;
  assign rsp1_result = res_q;
  assign rsp0_zero   = zero_q;
  assign rsp1_zero   = zero_q;
  assign rsp_take    = owner ? rsp1_ready : rsp0_ready;

  // Operand registers only change on capture, so the ALU inputs stay quiet between operations.
  assign alu_ip1       = ip1_q;
  assign alu_ip2       = ip2_q;
  assign alu_operation = op_q;
  assign state_dbg     = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      ip1_q      <= '0;
      ip2_q      <= '0;
      op_q       <= '0;
      res_q      <= '0;
      zero_q     <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_valid) begin
            ip1_q      <= grant_idx ? req1_ip1 : req0_ip1;
            ip2_q      <= grant_idx ? req1_ip2 : req0_ip2;
            op_q       <= grant_idx ? req1_op  : req0_op;
            owner      <= grant_idx;
            last_grant <= grant_idx;
            state      <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          res_q  <= alu_result;
          zero_q <= alu_zero_flag;
          state  <= ARB_RESP;
        end
        ARB_RESP: begin
          if (rsp_take) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

`ifdef ALU_SHARE_PERF_CNT_EN
  logic stall_cycle;
  assign stall_cycle = (req0_valid && !req0_ready) || (req1_valid && !req1_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grant0 <= '0;
      perf_grant1 <= '0;
      perf_stall  <= '0;
    end else begin
      if (req0_valid && req0_ready && (perf_grant0 != '1)) perf_grant0 <= perf_grant0 + CNT_W'(1);
      if (req1_valid && req1_ready && (perf_grant1 != '1)) perf_grant1 <= perf_grant1 + CNT_W'(1);
      if (stall_cycle && (perf_stall != '1)) perf_stall <= perf_stall + CNT_W'(1);
    end
  end
`endif

endmodule
